// File: rtl/clock_ctrl.sv
// Clock controller for SAP-3: integer divider, run/halt/step sequencer and
// per-channel glitch-free gated clocks built from latch-based gating cells.
module clock_ctrl #(
    parameter int N_CH   = 2,
    parameter int DIV_W  = 8,
    parameter int STEP_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              hlt,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic [DIV_W-1:0]  div,
    input  logic [N_CH-1:0]   ch_en,
    output logic [N_CH-1:0]   clk_out,
    output logic              tick,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [STEP_W-1:0]  steps_q;
    logic [STEP_W-1:0]  steps_d;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [DIV_W-1:0]   div_cnt_d;
    logic               armed_q;
    logic               gate_en;

    // armed keeps the first post-reset cycle from producing a tick
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        gate_en = armed_q && (div_cnt_q == '0) && !hlt &&
                  ((state_q == ST_RUN) ||
                   ((state_q == ST_STEP) && (steps_q != '0)));
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        case (state_q)
            ST_RUN: begin
                if (hlt || halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (hlt || halt_req) begin
                    state_d = ST_HALT;
                    steps_d = '0;
                end else if (resume) begin
                    state_d = ST_RUN;
                    steps_d = '0;
                end else if (gate_en) begin
                    steps_d = steps_q - STEP_W'(1);
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // a pending HLT or pause request outranks resume/step
                if (hlt || halt_req) begin
                    state_d = ST_HALT;
                end else if (resume) begin
                    state_d = ST_RUN;
                end else if (step && (step_cnt != '0)) begin
                    state_d = ST_STEP;
                    steps_d = step_cnt;
                end
            end
            default: begin
                state_d = ST_RUN;
                steps_d = '0;
            end
        endcase
    end

    // Held at zero while halted so the first tick after leaving HALT is immediate
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!armed_q) begin
            div_cnt_d = div_cnt_q;
        end else if ((state_q == ST_HALT) || (state_d == ST_HALT)) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == '0) begin
            div_cnt_d = div;
        end else begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            steps_q   <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            steps_q   <= steps_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick       = gate_en;
    assign state      = state_q;
    assign steps_left = steps_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_cg
`ifdef SYNTHESIS
        sg13g2_lgcp_1 u_cg (
            .GATE (gate_en & ch_en[i]),
            .CLK  (clk_in),
            .GCLK (clk_out[i])
        );
`else
        logic en_lat;
        // Transparent while clk_in is low, so enable changes in the high phase are blocked
        always_latch begin
            if (!clk_in) begin
                en_lat <= gate_en & ch_en[i];
            end
        end
        assign clk_out[i] = en_lat & clk_in;
`endif
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: per-cycle expectations queued, then popped
// and compared against tick/state/steps_left and the gated clock outputs.
module tb_clock_ctrl;

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;

    logic       clk_in;
    logic       rst_n;
    logic       hlt;
    logic       halt_req;
    logic       resume;
    logic       step;
    logic [7:0] step_cnt;
    logic [7:0] div;
    logic [1:0] ch_en;
    logic [1:0] clk_out;
    logic       tick;
    logic [1:0] state;
    logic [7:0] steps_left;

    logic [10:0] exp_q[$];
    int checks;
    int failures;

    clock_ctrl #(.N_CH(2), .DIV_W(8), .STEP_W(8)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .hlt        (hlt),
        .halt_req   (halt_req),
        .resume     (resume),
        .step       (step),
        .step_cnt   (step_cnt),
        .div        (div),
        .ch_en      (ch_en),
        .clk_out    (clk_out),
        .tick       (tick),
        .state      (state),
        .steps_left (steps_left)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic t, input logic [1:0] s, input logic [7:0] n);
        exp_q.push_back({t, s, n});
    endtask

    // Called at posedge+1; each entry covers one clk_in cycle
    task automatic drain(input string tag);
        logic [10:0] e;
        logic [1:0]  exp_clk;
        while (exp_q.size() > 0) begin
            @(negedge clk_in);
            e = exp_q.pop_front();
            check({tag, "_tick_state_steps"}, {5'b0, tick, state, steps_left}, {5'b0, e});
            exp_clk = e[10] ? ch_en : 2'b00;
            @(posedge clk_in);
            #1;
            check({tag, "_clk_out"}, {14'b0, clk_out}, {14'b0, exp_clk});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        hlt      = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        step     = 1'b0;
        step_cnt = 8'd0;
        div      = 8'd0;
        ch_en    = 2'b11;

        // reset values
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        check("rst_state", {14'b0, state}, {14'b0, S_RUN});
        check("rst_tick", {15'b0, tick}, 16'd0);
        check("rst_steps", {8'b0, steps_left}, 16'd0);
        check("rst_clk_out", {14'b0, clk_out}, 16'd0);
        rst_n = 1'b1;
        #1;
        check("unarmed_tick", {15'b0, tick}, 16'd0);
        @(posedge clk_in);
        #1;

        // div = 0: tick every cycle from cycle 1
        for (int i = 0; i < 4; i++) push(1'b1, S_RUN, 8'd0);
        drain("run_div0");

        // div = 3 then div = 1 mid-period
        div = 8'd3;
        for (int i = 0; i < 9; i++) push((i % 4) == 0, S_RUN, 8'd0);
        drain("run_div3");
        div = 8'd1;
        push(1'b0, S_RUN, 8'd0);
        push(1'b0, S_RUN, 8'd0);
        push(1'b0, S_RUN, 8'd0);
        for (int i = 0; i < 5; i++) push((i % 2) == 0, S_RUN, 8'd0);
        drain("run_div1");
        div = 8'd0;
        push(1'b0, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        drain("run_back_div0");

        // hlt suppresses the tick at once, HALT next cycle, resume ignored under hlt
        hlt = 1'b1;
        push(1'b0, S_RUN, 8'd0);
        drain("hlt_assert");
        resume = 1'b1;
        push(1'b0, S_HALT, 8'd0);
        drain("hlt_resume_ignored");
        resume = 1'b0;
        push(1'b0, S_HALT, 8'd0);
        push(1'b0, S_HALT, 8'd0);
        drain("hlt_held");
        hlt = 1'b0;
        push(1'b0, S_HALT, 8'd0);
        drain("hlt_released");
        resume = 1'b1;
        push(1'b0, S_HALT, 8'd0);
        drain("resume_pulse");
        resume = 1'b0;
        push(1'b1, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        drain("resume_run");

        // halt_req, then step bursts with div = 2
        halt_req = 1'b1;
        push(1'b1, S_RUN, 8'd0);
        drain("halt_req");
        halt_req = 1'b0;
        div = 8'd2;
        push(1'b0, S_HALT, 8'd0);
        drain("halted");
        step = 1'b1;
        step_cnt = 8'd0;
        push(1'b0, S_HALT, 8'd0);
        drain("step_zero");
        step = 1'b0;
        push(1'b0, S_HALT, 8'd0);
        drain("step_zero_ignored");
        step = 1'b1;
        step_cnt = 8'd3;
        push(1'b0, S_HALT, 8'd0);
        drain("step3_pulse");
        step = 1'b0;
        step_cnt = 8'd0;
        push(1'b1, S_STEP, 8'd3);
        push(1'b0, S_STEP, 8'd2);
        push(1'b0, S_STEP, 8'd2);
        push(1'b1, S_STEP, 8'd2);
        push(1'b0, S_STEP, 8'd1);
        push(1'b0, S_STEP, 8'd1);
        push(1'b1, S_STEP, 8'd1);
        push(1'b0, S_HALT, 8'd0);
        push(1'b0, S_HALT, 8'd0);
        drain("step3_burst");

        // halt_req beats resume during STEP
        step = 1'b1;
        step_cnt = 8'd5;
        push(1'b0, S_HALT, 8'd0);
        drain("step5_pulse");
        step = 1'b0;
        push(1'b1, S_STEP, 8'd5);
        push(1'b0, S_STEP, 8'd4);
        drain("step5_burst");
        halt_req = 1'b1;
        resume = 1'b1;
        push(1'b0, S_STEP, 8'd4);
        drain("step_halt_and_resume");
        halt_req = 1'b0;
        resume = 1'b0;
        push(1'b0, S_HALT, 8'd0);
        push(1'b0, S_HALT, 8'd0);
        drain("step_halt_wins");

        // resume alone during STEP
        step = 1'b1;
        step_cnt = 8'd4;
        push(1'b0, S_HALT, 8'd0);
        drain("step4_pulse");
        step = 1'b0;
        push(1'b1, S_STEP, 8'd4);
        drain("step4_burst");
        resume = 1'b1;
        push(1'b0, S_STEP, 8'd3);
        drain("step_resume");
        resume = 1'b0;
        push(1'b0, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        drain("step_to_run");

        // single channel enabled
        div = 8'd0;
        ch_en = 2'b01;
        push(1'b0, S_RUN, 8'd0);
        push(1'b0, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        drain("ch_en01");

        // ch_en toggled in the high phase: pulse already started stays full width
        ch_en = 2'b00;
        #1;
        check("glitch_hi_a", {14'b0, clk_out}, 16'h0001);
        ch_en = 2'b01;
        #1;
        check("glitch_hi_b", {14'b0, clk_out}, 16'h0001);
        ch_en = 2'b00;
        #1;
        check("glitch_hi_c", {14'b0, clk_out}, 16'h0001);
        ch_en = 2'b01;
        @(negedge clk_in);
        #1;
        check("glitch_lo_phase", {14'b0, clk_out}, 16'h0000);
        @(posedge clk_in);
        #1;
        check("glitch_next_pulse", {14'b0, clk_out}, 16'h0001);

        // ch_en raised in the high phase of a gated-off cycle cannot start a pulse
        ch_en = 2'b00;
        @(posedge clk_in);
        #1;
        check("runt_a", {14'b0, clk_out}, 16'h0000);
        ch_en = 2'b01;
        #1;
        check("runt_b", {14'b0, clk_out}, 16'h0000);
        ch_en = 2'b00;
        #1;
        check("runt_c", {14'b0, clk_out}, 16'h0000);
        ch_en = 2'b01;
        @(posedge clk_in);
        #1;
        check("runt_recover", {14'b0, clk_out}, 16'h0001);

        // async reset in the middle of a step burst
        halt_req = 1'b1;
        push(1'b1, S_RUN, 8'd0);
        drain("pre_rst_halt");
        halt_req = 1'b0;
        step = 1'b1;
        step_cnt = 8'd6;
        push(1'b0, S_HALT, 8'd0);
        drain("pre_rst_step");
        step = 1'b0;
        push(1'b1, S_STEP, 8'd6);
        push(1'b1, S_STEP, 8'd5);
        drain("pre_rst_burst");
        rst_n = 1'b0;
        #1;
        check("midrst_clk_hold", {14'b0, clk_out}, 16'h0001);
        check("midrst_state", {14'b0, state}, {14'b0, S_RUN});
        check("midrst_steps", {8'b0, steps_left}, 16'd0);
        check("midrst_tick", {15'b0, tick}, 16'd0);
        @(negedge clk_in);
        #1;
        check("midrst_clk_low", {14'b0, clk_out}, 16'h0000);
        @(posedge clk_in);
        #1;
        check("midrst_no_pulse", {14'b0, clk_out}, 16'h0000);
        @(negedge clk_in);
        #1;
        rst_n = 1'b1;
        #1;
        check("rerst_unarmed_tick", {15'b0, tick}, 16'd0);
        @(posedge clk_in);
        #1;
        push(1'b1, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        push(1'b1, S_RUN, 8'd0);
        drain("post_rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
